mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory-access pipeline stage of the 4-stage datapath, sitting between execute and writeback.
- Upstream, it takes execute results over a valid/ready handshake.
- It drives the 16x256 data memory: synchronous write port, combinational read port.
- Downstream, it presents load and ALU results to writeback over a valid/ready handshake.
- Byte stores use a two-cycle read-modify-write (RMW). This keeps the combinational read, merge and write path out of a single cycle.
- Two saturating event counters are provided for debug.

Parameters:
DW, 16, data word width (must be 16; byte ops assume two 8-bit lanes)
AW, 8, memory address width
RW, 3, destination register index width
CW, 16, counter width

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  execute result valid
in_ready  out  1  stage accepts in this cycle
in_op  in  3  operation: 000 NOP, 001 ALU, 010 LW, 011 SW, 100 SBL, 101 SBH, 110 LBL, 111 LBH
in_addr  in  AW  memory address
in_data  in  DW  store data, or ALU result for ALU
in_rd  in  RW  destination register
flush  in  1  synchronous pipeline flush
mem_wt_en  out  1  memory write enable
mem_wt_addr  out  AW  memory write address
mem_data_wt  out  DW  memory write data
mem_rd_addr  out  AW  memory read address
mem_read_out  in  DW  memory read data (combinational)
out_valid  out  1  writeback entry valid
out_ready  in  1  writeback accepts
out_rd  out  RW  writeback destination
out_data  out  DW  writeback data
busy  out  1  state != IDLE
ld_cnt  out  CW  loads completed
st_cnt  out  CW  stores completed

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset forces state=IDLE, out_valid=0, out_rd=0, out_data=0, ld_cnt=0, st_cnt=0 and all internal latches to 0.
- mem_wt_en is forced to 0 while rst=1.
- FSM states: IDLE and RMW_WR.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- fire = in_valid && in_ready.
- IDLE memory drive (combinational): mem_rd_addr=in_addr, mem_wt_addr=in_addr, mem_data_wt=in_data.
- IDLE write enable: mem_wt_en = fire && op==SW.
- SW: the write lands at the fire edge. No writeback entry. st_cnt increments.
- LW/LBL/LBH: at the fire edge, out_data is loaded and out_valid=1, out_rd=in_rd. ld_cnt increments.
  - LW: out_data = mem_read_out.
  - LBL: out_data = {8'h00, mem_read_out[7:0]}.
  - LBH: out_data = {8'h00, mem_read_out[15:8]}.
  - Load latency is 1 cycle from fire to out_valid.
- ALU: at fire, out_data=in_data, out_rd=in_rd, out_valid=1. No memory write.
- NOP: consumed at fire. No effect.
- SBL/SBH at fire: latch addr and merged word into internal registers, then go to RMW_WR.
  - SBL merged word = {mem_read_out[15:8], in_data[7:0]}.
  - SBH merged word = {in_data[7:0], mem_read_out[7:0]}.
- RMW_WR (one cycle):
  - in_ready=0.
  - mem_wt_addr and mem_rd_addr are driven from the latched address. mem_data_wt is the latched merged word. mem_wt_en=1 unless flush.
  - At the next edge: state=IDLE and st_cnt increments.
  - If flush=1 in this cycle: mem_wt_en=0, no increment, return to IDLE.
- Output register: out_valid clears at an edge where out_ready=1 and no new fire loads it. Back-to-back fire with out_ready=1 sustains 1 result/cycle.
  - out_data and out_rd hold while out_valid && !out_ready.
- flush=1 (synchronous): out_valid clears at the next edge, no fire occurs, and an RMW_WR in progress is aborted without a write.
- Ordering:
  - A load accepted the cycle after a SW or RMW_WR to the same address reads the new value, because the write has landed at the prior edge.
  - No same-cycle read/write hazard exists: one operation is in flight per cycle.
- Counters saturate at all-ones and never wrap.
- Async reset during RMW_WR: no write occurs (mem_wt_en forced 0), state returns to IDLE.

Test Plan:
- Reset, then SW addr 0x10 data 0xBEEF, then LW addr 0x10 rd 3 -> mem[0x10]=0xBEEF; out_valid=1 one cycle after LW fire, out_rd=3, out_data=0xBEEF; ld_cnt=1, st_cnt=1.
- mem[0x20]=0x1234; SBH data 0x00AB; next cycle in_ready=0 and busy=1; then LBH 0x20 and LBL 0x20 -> mem[0x20]=0xAB34; LBH returns 0x00AB, LBL returns 0x0034.
- ALU result 0x5555 rd 2 with out_ready=0 for 3 cycles -> out_valid and out_data stable; in_ready=0; the next op is accepted on the cycle out_ready=1.
- Assert flush during SBL RMW_WR to 0x30 (old value 0xFFFF) -> mem_wt_en stays 0; mem[0x30]=0xFFFF; st_cnt unchanged; state IDLE next cycle.
- Assert rst mid-stream while out_valid=1 and in RMW_WR -> outputs and counters are 0 immediately; no memory write.
- Preload ld_cnt near 0xFFFF, then issue 3 more loads -> ld_cnt stays 0xFFFF.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: forwards ALU results, performs word/byte loads
// and stores against a sync-write/comb-read memory, with two-cycle byte RMW.
module mem_access_stage #(
    parameter int DW = 16,
    parameter int AW = 8,
    parameter int RW = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic [RW-1:0] in_rd,
    input  logic          flush,
    output logic          mem_wt_en,
    output logic [AW-1:0] mem_wt_addr,
    output logic [DW-1:0] mem_data_wt,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_read_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_rd,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic [CW-1:0] ld_cnt,
    output logic [CW-1:0] st_cnt
);

    typedef enum logic {IDLE, RMW_WR} state_e;
    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ALU = 3'b001,
        OP_LW  = 3'b010,
        OP_SW  = 3'b011,
        OP_SBL = 3'b100,
        OP_SBH = 3'b101,
        OP_LBL = 3'b110,
        OP_LBH = 3'b111
    } op_e;

    state_e        state_q, state_d;
    logic [AW-1:0] rmw_addr_q, rmw_addr_d;
    logic [DW-1:0] rmw_data_q, rmw_data_d;
    logic          out_valid_q, out_valid_d;
    logic [RW-1:0] out_rd_q, out_rd_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [CW-1:0] ld_cnt_q, ld_cnt_d;
    logic [CW-1:0] st_cnt_q, st_cnt_d;

    op_e           op;
    logic          ready_c;
    logic          fire;
    logic          wt_en_c;
    logic          writes_back;
    logic [DW-1:0] load_word;

    assign op = op_e'(in_op);

    always_comb begin
        ready_c     = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
        fire        = in_valid && ready_c;
        writes_back = (op == OP_ALU) || (op == OP_LW) || (op == OP_LBL) || (op == OP_LBH);

        state_d     = state_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_data_d  = rmw_data_q;
        out_valid_d = out_valid_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        ld_cnt_d    = ld_cnt_q;
        st_cnt_d    = st_cnt_q;

        wt_en_c     = 1'b0;
        mem_wt_addr = in_addr;
        mem_rd_addr = in_addr;
        mem_data_wt = in_data;

        case (op)
            OP_LBL:  load_word = {{(DW-8){1'b0}}, mem_read_out[7:0]};
            OP_LBH:  load_word = {{(DW-8){1'b0}}, mem_read_out[15:8]};
            OP_ALU:  load_word = in_data;
            default: load_word = mem_read_out;
        endcase

        if (state_q == RMW_WR) begin
            mem_wt_addr = rmw_addr_q;
            mem_rd_addr = rmw_addr_q;
            mem_data_wt = rmw_data_q;
            wt_en_c     = !flush;
            state_d     = IDLE;
            if (!flush && st_cnt_q != '1)
                st_cnt_d = st_cnt_q + CW'(1);
        end else if (fire) begin
            case (op)
                OP_SW: begin
                    wt_en_c = 1'b1;
                    if (st_cnt_q != '1)
                        st_cnt_d = st_cnt_q + CW'(1);
                end
                OP_LW, OP_LBL, OP_LBH: begin
                    if (ld_cnt_q != '1)
                        ld_cnt_d = ld_cnt_q + CW'(1);
                end
                OP_SBL: begin
                    rmw_addr_d = in_addr;
                    rmw_data_d = {mem_read_out[DW-1:8], in_data[7:0]};
                    state_d    = RMW_WR;
                end
                OP_SBH: begin
                    rmw_addr_d = in_addr;
                    rmw_data_d = {in_data[7:0], mem_read_out[7:0]};
                    state_d    = RMW_WR;
                end
                default: ;
            endcase
        end

        // Flush wins over a new load; otherwise a drained entry clears unless refilled.
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire && writes_back) begin
            out_valid_d = 1'b1;
            out_rd_d    = in_rd;
            out_data_d  = load_word;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rmw_addr_q  <= '0;
            rmw_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            ld_cnt_q    <= '0;
            st_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_data_q  <= rmw_data_d;
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            ld_cnt_q    <= ld_cnt_d;
            st_cnt_q    <= st_cnt_d;
        end
    end

    assign mem_wt_en = wt_en_c && !rst;
    assign in_ready  = ready_c;
    assign out_valid = out_valid_q;
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
    assign ld_cnt    = ld_cnt_q;
    assign st_cnt    = st_cnt_q;

endmodule
